fft_input_loader: RTL and testbench
===================================

# fft_input_loader

Front-end writer for the radix-4 FFT core. It accepts a 2048-point complex sample stream over a valid/ready handshake and writes each sample into the four 512-word input banks in the layout the FFT controller reads on stage 0: sample n goes to bank n[10:9], word n[8:0]. After the frame completes, it pulses start to the FFT controller and holds off new input until the controller reports ready again. It sits between the sample source and the bank-A write port, and owns that port whenever the FFT core is idle.

## Interface
Parameters:
- DATA_W, 16, width of each real/imaginary component

Ports:
- iCLK  in  1  clock
- iRESET  in  1  reset, asynchronous, active-low
- iS_VALID  in  1  input sample valid
- iS_RE  in  DATA_W  sample real part
- iS_IM  in  DATA_W  sample imaginary part
- iS_LAST  in  1  marks the final (2048th) sample of a frame
- oS_READY  out  1  loader can accept a sample this cycle
- oWE  out  4  one-hot bank write enable, bit k selects bank k
- oADDR  out  9  word address within the bank
- oDATA_RE  out  DATA_W  write data, real part
- oDATA_IM  out  DATA_W  write data, imaginary part
- iFFT_RDY  in  1  FFT controller ready/idle level
- oFFT_START  out  1  one-cycle start pulse to the FFT controller
- oERR_LAST  out  1  one-cycle pulse on frame-length mismatch
- oBUSY  out  1  high from first accepted sample until FFT completion

## Operation
- Internal 11-bit sample counter cnt. States: LOAD, FLUSH, START, WAIT_ACK, WAIT_DONE.
- LOAD: oS_READY = iFFT_RDY. Accept on iS_VALID & oS_READY. On each accept, register data and set oWE = 1 << cnt[10:9], oADDR = cnt[8:0], then cnt += 1. oBUSY is set on the first accept.
- Early last (iS_LAST on accept with cnt != 2047): the sample is still written. oERR_LAST pulses, cnt is cleared, and the loader stays in LOAD. The partial frame is discarded and is overwritten by the next frame.
- Missing last (accept at cnt == 2047 with iS_LAST = 0): oERR_LAST pulses, but the frame is treated as complete and processing continues normally.
- Accept at cnt == 2047 → FLUSH, and cnt wraps to 0.
- FLUSH: one cycle. The last write drains and oS_READY = 0. Next state is START.
- START: oFFT_START = 1 for exactly one cycle. Next state is WAIT_ACK.
- WAIT_ACK: wait for iFFT_RDY = 0, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: wait for iFFT_RDY = 1. Then clear oBUSY and return to LOAD.
- oS_READY is 0 in every state except LOAD.
- oWE is 0 in any cycle that does not follow an accept.
- Data is passed through unmodified. No scaling or saturation.

## Timing
- Reset values: state LOAD, cnt 0, oWE 0, oADDR 0, oDATA_RE/IM 0, oFFT_START 0, oERR_LAST 0, oBUSY 0.
- oS_READY is combinational from state and iFFT_RDY.
- Reset asserted mid-frame or mid-FFT aborts immediately with no write and no start pulse. The loader restarts at cnt 0.
- Write latency is 1 cycle: accept at edge t → oWE/oADDR/oDATA valid in cycle t+1.
- oERR_LAST is registered and valid in cycle t+1 for an accept at t.
- Final accept at t: the last write occurs in cycle t+1 and oFFT_START is high in cycle t+2. The controller drops ready one edge later, so WAIT_ACK lasts 1 cycle when the controller behaves.
- Back-to-back accepts sustain 1 sample per cycle, so a full frame loads in 2048 cycles minimum.
- If iFFT_RDY falls during LOAD, oS_READY drops the same cycle. cnt and the partial frame are held.

## Structure
- Shared package fft_pkg holds: FFT_N = 2048, BANK_NUM = 4, BANK_DEPTH = 512, BANK_ADDR_W = 9, and the loader state enum.
- Single flat module. No sub-module is warranted.
- The top-level mux granting this block the bank-A write port on iFFT_RDY lives in the FFT top level, not in this block.

## Test plan
- Full frame, valid always high, iS_LAST on sample 2047 → 2048 writes. Sample 0 goes to bank 0 word 0; sample 513 goes to oWE=4'b0010, oADDR=1; sample 2047 goes to oWE=4'b1000, oADDR=511. oFFT_START pulses 2 cycles after the last accept, and oERR_LAST stays 0.
- Random valid gaps (50% duty) → identical bank contents to the back-to-back case, and exactly one start pulse.
- iS_LAST on sample 100 → oERR_LAST pulses 1 cycle after that accept. The next sample is written to bank 0 word 0, and no start pulse occurs.
- Sample 2047 without iS_LAST → oERR_LAST and oFFT_START both pulse, and the loader proceeds to WAIT_ACK.
- iFFT_RDY held low for 3000 cycles after start, then raised → oS_READY stays 0 and oBUSY stays 1 throughout. Both change the cycle after iFFT_RDY rises.
- iRESET pulsed low after 700 samples → all outputs return to reset values asynchronously. The next accepted sample is written to bank 0 word 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT front-end constants: frame size, input bank geometry and the loader state encoding.
package fft_pkg;

  localparam int FFT_N       = 2048;
  localparam int BANK_NUM    = 4;
  localparam int BANK_DEPTH  = 512;
  localparam int BANK_ADDR_W = 9;
  localparam int CNT_W       = $clog2(FFT_N);
  localparam int BANK_SEL_W  = $clog2(BANK_NUM);

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } loader_state_e;

  function automatic logic [BANK_NUM-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] sel);
    bank_onehot      = '0;
    bank_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Loads a 2048-sample frame into four 512-word banks (sample n -> bank n[10:9], word n[8:0]) one cycle
// after each accept, then pulses start and keeps oS_READY low until the FFT controller is idle again.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iS_VALID,
  input  logic [DATA_W-1:0]      iS_RE,
  input  logic [DATA_W-1:0]      iS_IM,
  input  logic                   iS_LAST,
  output logic                   oS_READY,
  output logic [BANK_NUM-1:0]    oWE,
  output logic [BANK_ADDR_W-1:0] oADDR,
  output logic [DATA_W-1:0]      oDATA_RE,
  output logic [DATA_W-1:0]      oDATA_IM,
  input  logic                   iFFT_RDY,
  output logic                   oFFT_START,
  output logic                   oERR_LAST,
  output logic                   oBUSY
);

  loader_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BANK_NUM-1:0]    we_q, we_d;
  logic [BANK_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      re_q, re_d;
  logic [DATA_W-1:0]      im_q, im_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   accept;
  logic                   at_end;

  assign oS_READY   = (state_q == ST_LOAD) && iFFT_RDY;
  assign accept     = iS_VALID && oS_READY;
  assign at_end     = (cnt_q == CNT_W'(FFT_N - 1));

  assign oWE        = we_q;
  assign oADDR      = addr_q;
  assign oDATA_RE   = re_q;
  assign oDATA_IM   = im_q;
  assign oERR_LAST  = err_q;
  assign oBUSY      = busy_q;
  assign oFFT_START = (state_q == ST_START);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = '0;
    addr_d  = addr_q;
    re_d    = re_q;
    im_d    = im_q;
    err_d   = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          we_d   = bank_onehot(cnt_q[CNT_W-1:BANK_ADDR_W]);
          addr_d = cnt_q[BANK_ADDR_W-1:0];
          re_d   = iS_RE;
          im_d   = iS_IM;
          busy_d = 1'b1;
          // A mismatch is flagged either way; only an early last abandons the frame.
          err_d  = (iS_LAST != at_end);
          if (at_end) begin
            cnt_d   = '0;
            state_d = ST_FLUSH;
          end else if (iS_LAST) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!iFFT_RDY) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (iFFT_RDY) begin
          busy_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      re_q    <= '0;
      im_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      im_q    <= im_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: frame-level reference model with a scripted FFT controller, plus a table of address-map spot checks.
module tb_fft_input_loader;
  import fft_pkg::*;

  localparam int DW = 16;

  logic           iCLK = 1'b0;
  logic           iRESET;
  logic           iS_VALID;
  logic [DW-1:0]  iS_RE;
  logic [DW-1:0]  iS_IM;
  logic           iS_LAST;
  logic           oS_READY;
  logic [3:0]     oWE;
  logic [8:0]     oADDR;
  logic [DW-1:0]  oDATA_RE;
  logic [DW-1:0]  oDATA_IM;
  logic           iFFT_RDY;
  logic           oFFT_START;
  logic           oERR_LAST;
  logic           oBUSY;

  always #5 iCLK = ~iCLK;

  fft_input_loader #(.DATA_W(DW)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iS_VALID(iS_VALID), .iS_RE(iS_RE), .iS_IM(iS_IM), .iS_LAST(iS_LAST),
    .oS_READY(oS_READY), .oWE(oWE), .oADDR(oADDR),
    .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM),
    .iFFT_RDY(iFFT_RDY), .oFFT_START(oFFT_START),
    .oERR_LAST(oERR_LAST), .oBUSY(oBUSY)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state (frame-level view) ----------------
  int          pos;         // index of the next sample within the current frame
  bit          loading;     // loader is accepting frames
  bit          busy_m;
  bit          low_seen;    // controller has dropped ready since the start pulse
  int          start_due;   // cycles until start pulse is due, 0 = none pending
  bit          pw;          // a write is expected this cycle
  bit          pw_err;
  int          pw_bank;
  logic [8:0]  pw_addr;
  logic [31:0] pw_dat;
  bit          acc_flag;
  logic [31:0] fbuf [FFT_N];
  logic [31:0] mem  [BANK_NUM][BANK_DEPTH];
  logic [3:0]  log_we   [FFT_N];
  logic [8:0]  log_addr [FFT_N];
  int          log_n;
  int          n_start, n_err, cyc;

  // scripted FFT controller
  bit ctl_pending;
  int ctl_left;
  int ctl_len;
  bit jitter;

  task automatic model_reset();
    pos = 0; loading = 1'b1; busy_m = 1'b0; low_seen = 1'b0; start_due = 0;
    pw = 1'b0; pw_err = 1'b0; pw_bank = 0; pw_addr = '0; pw_dat = '0;
    ctl_pending = 1'b0; ctl_left = 0;
  endtask

  task automatic tick();
    bit exp_start;
    bit acc;
    @(negedge iCLK);
    cyc++;
    exp_start = 1'b0;
    if (start_due > 0) begin
      start_due--;
      exp_start = (start_due == 0);
    end
    check("s_ready", oS_READY, loading && iFFT_RDY);
    check("busy", oBUSY, busy_m);
    check("we", oWE, pw ? (4'b0001 << pw_bank) : 4'b0000);
    if (pw) begin
      check("addr", oADDR, pw_addr);
      check("data", {oDATA_RE, oDATA_IM}, pw_dat);
    end
    check("err_last", oERR_LAST, pw_err);
    check("fft_start", oFFT_START, exp_start);

    for (int k = 0; k < BANK_NUM; k++)
      if (oWE[k]) mem[k][oADDR] = {oDATA_RE, oDATA_IM};
    if (oWE != 4'b0000 && log_n < FFT_N) begin
      log_we[log_n] = oWE; log_addr[log_n] = oADDR; log_n++;
    end
    if (oFFT_START) begin n_start++; ctl_pending = 1'b1; end
    if (oERR_LAST) n_err++;

    acc = loading && iFFT_RDY && iS_VALID;
    acc_flag = acc_flag | acc;
    pw = acc;
    pw_err = 1'b0;
    if (acc) begin
      pw_bank = pos / BANK_DEPTH;
      pw_addr = 9'(pos % BANK_DEPTH);
      pw_dat  = {iS_RE, iS_IM};
      fbuf[pos] = pw_dat;
      busy_m = 1'b1;
      if (pos == FFT_N - 1) begin
        pw_err = !iS_LAST; pos = 0; loading = 1'b0; low_seen = 1'b0; start_due = 2;
      end else if (iS_LAST) begin
        pw_err = 1'b1; pos = 0;
      end else begin
        pos++;
      end
    end else if (!loading && start_due == 0) begin
      if (!iFFT_RDY) low_seen = 1'b1;
      else if (low_seen) begin loading = 1'b1; busy_m = 1'b0; end
    end

    @(posedge iCLK);
    #1;
    if (ctl_pending) begin
      ctl_pending = 1'b0; ctl_left = ctl_len; iFFT_RDY = 1'b0;
    end else if (ctl_left > 0) begin
      ctl_left--;
      if (ctl_left == 0) iFFT_RDY = 1'b1;
    end else begin
      iFFT_RDY = (jitter && loading) ? ($urandom_range(7, 0) != 0) : 1'b1;
    end
  endtask

  task automatic send(input bit last, input bit gaps);
    int guard = 0;
    iS_VALID = 1'b0;
    while (gaps && $urandom_range(1, 0) == 1) tick();
    iS_VALID = 1'b1;
    iS_RE    = 16'($urandom);
    iS_IM    = 16'($urandom);
    iS_LAST  = last;
    acc_flag = 1'b0;
    while (!acc_flag && guard < 5000) begin tick(); guard++; end
    if (!acc_flag) check("accept_timeout", 0, 1);
    iS_VALID = 1'b0;
    iS_LAST  = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input bit with_last);
    for (int i = 0; i < FFT_N; i++) send(with_last && (i == FFT_N - 1), gaps);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int g = 0;
    while (!loading && g < bound) begin tick(); g++; end
    check(name, loading, 1'b1);
  endtask

  task automatic check_banks(input string name);
    int mism = 0;
    for (int n = 0; n < FFT_N; n++)
      if (mem[n / BANK_DEPTH][n % BANK_DEPTH] !== fbuf[n]) mism++;
    check(name, mism, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    oWE, 4'b0000);
    check({tag, "_addr"},  oADDR, 9'd0);
    check({tag, "_re"},    oDATA_RE, 16'd0);
    check({tag, "_im"},    oDATA_IM, 16'd0);
    check({tag, "_start"}, oFFT_START, 1'b0);
    check({tag, "_err"},   oERR_LAST, 1'b0);
    check({tag, "_busy"},  oBUSY, 1'b0);
  endtask

  typedef struct {
    int         idx;
    logic [3:0] we;
    logic [8:0] addr;
  } map_vec_t;

  map_vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int s0, e0, c0;
    tbl[0] = '{0,    4'b0001, 9'd0};
    tbl[1] = '{1,    4'b0001, 9'd1};
    tbl[2] = '{511,  4'b0001, 9'd511};
    tbl[3] = '{512,  4'b0010, 9'd0};
    tbl[4] = '{513,  4'b0010, 9'd1};
    tbl[5] = '{1024, 4'b0100, 9'd0};
    tbl[6] = '{1535, 4'b0100, 9'd511};
    tbl[7] = '{1536, 4'b1000, 9'd0};
    tbl[8] = '{2000, 4'b1000, 9'd464};
    tbl[9] = '{2047, 4'b1000, 9'd511};

    iRESET = 1'b0; iS_VALID = 1'b0; iS_RE = '0; iS_IM = '0; iS_LAST = 1'b0; iFFT_RDY = 1'b1;
    ctl_len = 4; jitter = 1'b0; log_n = 0; n_start = 0; n_err = 0; cyc = 0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    tick();

    // Full frame, back to back
    log_n = 0; s0 = n_start; e0 = n_err;
    send_frame(1'b0, 1'b1);
    wait_idle("a_return", 100);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("map%0d_we", tbl[i].idx), log_we[tbl[i].idx], tbl[i].we);
      check($sformatf("map%0d_addr", tbl[i].idx), log_addr[tbl[i].idx], tbl[i].addr);
    end
    check("a_starts", n_start - s0, 1);
    check("a_errs", n_err - e0, 0);
    check_banks("a_banks");

    // Random valid gaps plus ready dips while loading
    jitter = 1'b1; s0 = n_start; e0 = n_err;
    send_frame(1'b1, 1'b1);
    jitter = 1'b0;
    wait_idle("b_return", 100);
    check("b_starts", n_start - s0, 1);
    check("b_errs", n_err - e0, 0);
    check_banks("b_banks");

    // Early last on sample 100, then a frame with a missing last
    s0 = n_start; e0 = n_err;
    for (int i = 0; i <= 100; i++) send(i == 100, 1'b0);
    check("early_err_pulse", oERR_LAST, 1'b1);
    send(1'b0, 1'b0);
    check("early_next_we", oWE, 4'b0001);
    check("early_next_addr", oADDR, 9'd0);
    check("early_no_start", n_start - s0, 0);
    for (int i = 1; i < FFT_N; i++) send(1'b0, 1'b0);
    check("missing_err_pulse", oERR_LAST, 1'b1);
    tick();
    check("missing_start_pulse", oFFT_START, 1'b1);
    wait_idle("c_return", 100);
    check("c_starts", n_start - s0, 1);
    check("c_errs", n_err - e0, 2);

    // Controller holds ready low for a long FFT
    ctl_len = 3000;
    send_frame(1'b0, 1'b1);
    c0 = cyc;
    wait_idle("stall_return", 4000);
    check("stall_long_enough", (cyc - c0) >= 3000, 1'b1);
    ctl_len = 4;

    // Asynchronous reset mid-frame
    for (int i = 0; i < 700; i++) send(1'b0, 1'b1);
    #2;
    iRESET = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(posedge iCLK); #1;
    check("arst_hold_we", oWE, 4'b0000);
    check("arst_hold_start", oFFT_START, 1'b0);
    iRESET = 1'b1;
    iFFT_RDY = 1'b1;
    model_reset();
    send(1'b0, 1'b0);
    check("arst_next_we", oWE, 4'b0001);
    check("arst_next_addr", oADDR, 9'd0);
    for (int i = 0; i < 8; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
